// File: rtl/core_pkg.sv
// Shared RV32I core definitions: widths, reset constants and the fetch FSM encoding.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline stage register: load beats flush, flush beats stall, and an
// unstalled stage with nothing new to load drains to the bubble value.
module if_id_reg #(
  parameter int         W      = 65,
  parameter logic [W-1:0] BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         flush,
  input  logic         stall,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] dout
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= BUBBLE;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (flush || !stall) begin
      valid <= 1'b0;
      dout  <= BUBBLE;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch front end: owns the PC, issues one imem read at a time,
// squashes stale responses after redirect/reset and feeds decode via IF/ID.
module instr_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  output logic         if_valid,
  output logic [31:0]  if_pc,
  output logic [31:0]  if_instr,
  output logic         if_misalign,
  output fetch_state_e dbg_state
);

  // Memory handshake: imem_req is accepted in the cycle it is high; exactly one
  // imem_rvalid pulse answers each request, at least one cycle later.

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_q, buf_d;
  logic         drop_q, drop_d;
  logic         pend_q, pend_d;

  logic         slot_free;
  logic         ifid_load;
  logic         ifid_flush;
  logic [31:0]  ifid_instr;
  logic [64:0]  ifid_dout;

  assign slot_free  = !if_valid || !stall || flush;
  assign ifid_flush = flush || redirect_valid;
  assign imem_req   = (state_q == ST_FETCH) && !rst;
  assign imem_addr  = word_align(pc_q);
  assign dbg_state  = state_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    drop_d     = drop_q;
    pend_d     = pend_q;
    ifid_load  = 1'b0;
    ifid_instr = buf_q;

    if (redirect_valid) begin
      pc_d   = redirect_pc & ~32'h3;
      pend_d = |redirect_pc[1:0];
      case (state_q)
        ST_FETCH: begin
          // The request going out this cycle belongs to the old path.
          state_d = ST_WAIT;
          drop_d  = 1'b1;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            state_d = ST_FETCH;
            drop_d  = 1'b0;
          end else begin
            state_d = ST_WAIT;
            drop_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_FETCH;
          drop_d  = 1'b0;
        end
      endcase
    end else begin
      case (state_q)
        ST_FETCH: begin
          state_d = ST_WAIT;
          // A late answer to a request killed by reset may land here.
          if (imem_rvalid && drop_q) drop_d = 1'b0;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = ST_FETCH;
            end else if (slot_free) begin
              ifid_load  = 1'b1;
              ifid_instr = imem_rdata;
              pc_d       = pc_q + 32'd4;
              pend_d     = 1'b0;
              state_d    = ST_FETCH;
            end else begin
              buf_d   = imem_rdata;
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (slot_free) begin
            ifid_load  = 1'b1;
            ifid_instr = buf_q;
            pc_d       = pc_q + 32'd4;
            pend_d     = 1'b0;
            state_d    = ST_FETCH;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= word_align(RESET_PC);
      buf_q   <= 32'h0;
      pend_q  <= 1'b0;
      // A request still in flight when reset hits must not reach IF/ID later.
      drop_q  <= drop_q | (state_q == ST_WAIT);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  if_id_reg #(
    .W      (65),
    .BUBBLE ({1'b0, 32'h0, NOP_INSTR})
  ) u_if_id (
    .clk   (clk),
    .rst   (rst),
    .load  (ifid_load),
    .flush (ifid_flush),
    .stall (stall),
    .din   ({pend_q, pc_q, ifid_instr}),
    .valid (if_valid),
    .dout  (ifid_dout)
  );

  assign if_misalign = ifid_dout[64];
  assign if_pc       = ifid_dout[63:32];
  assign if_instr    = ifid_dout[31:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: cycle table, directed corner sequences, then random
// stall/redirect traffic checked against an in-order instruction-stream model.
module tb_instr_fetch;
  import core_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         rst, stall, flush, redirect_valid;
  logic [31:0]  redirect_pc;
  logic         imem_req, imem_rvalid;
  logic [31:0]  imem_addr, imem_rdata;
  logic         if_valid, if_misalign;
  logic [31:0]  if_pc, if_instr;
  fetch_state_e dbg_state;

  instr_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_misalign(if_misalign), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // memory model state
  bit          mem_pend = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = 32'h0;
  int          lat_min  = 1;
  int          lat_max  = 1;
  bit          poison   = 1'b0;

  typedef struct {
    bit           st;
    bit           exp_req;
    logic [31:0]  exp_addr;
    bit           exp_valid;
    logic [31:0]  exp_pc;
    logic [31:0]  exp_instr;
    fetch_state_e exp_state;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00a0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic vec_t mk(input bit st, input bit req, input logic [31:0] addr,
                              input bit v, input logic [31:0] pc, input logic [31:0] ins,
                              input fetch_state_e s);
    vec_t r;
    r.st = st; r.exp_req = req; r.exp_addr = addr; r.exp_valid = v;
    r.exp_pc = pc; r.exp_instr = ins; r.exp_state = s;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs (at a negedge), let the memory answer or accept.
  task automatic apply(input bit st, input bit fl, input bit rv, input logic [31:0] rpc);
    stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = poison ? 32'hDEAD_BEEF : mem_word(mem_addr);
        poison      = 1'b0;
        mem_pend    = 1'b0;
      end
    end
    #1;
    if (imem_req) begin
      chk("one_outstanding", {31'b0, mem_pend}, 32'h0);
      chk("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
      mem_pend = 1'b1;
      mem_cnt  = int'($urandom_range(lat_max, lat_min));
      mem_addr = imem_addr;
    end
  endtask

  task automatic advance();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply(1'b0, 1'b0, 1'b0, 32'h0);
      advance();
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 10 && dbg_state == ST_WAIT; i++) begin
      apply(1'b0, 1'b0, 1'b0, 32'h0);
      advance();
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 1'b0, 1'b0, 32'h0);
      chk("rst_req", {31'b0, imem_req}, 32'h0);
      if (i == 1) begin
        chk("rst_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, NOP);
        chk("rst_misalign", {31'b0, if_misalign}, 32'h0);
      end
      advance();
    end
    rst = 1'b0;
  endtask

  // Redirect issued from FETCH, then follow the new target: wrap/misalign cases.
  task automatic redirect_from_fetch(input string tag, input logic [31:0] rpc);
    logic [31:0] tgt;
    tgt = rpc & ~32'h3;
    do_reset();
    lat_min = 1; lat_max = 1;
    apply(1'b0, 1'b0, 1'b1, rpc);
    chk({tag, "_fetch_state"}, 32'(dbg_state), 32'(ST_FETCH));
    advance();
    idle(1);
    apply(1'b0, 1'b0, 1'b0, 32'h0);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'h1);
    chk({tag, "_addr"}, imem_addr, tgt);
    advance();
    apply(1'b0, 1'b0, 1'b0, 32'h0);
    chk({tag, "_no_stale"}, {31'b0, if_valid}, 32'h0);
    advance();
    apply(1'b0, 1'b0, 1'b0, 32'h0);
    chk({tag, "_valid"}, {31'b0, if_valid}, 32'h1);
    chk({tag, "_pc"}, if_pc, tgt);
    chk({tag, "_instr"}, if_instr, mem_word(tgt));
    chk({tag, "_mis"}, {31'b0, if_misalign}, {31'b0, |rpc[1:0]});
    chk({tag, "_next_addr"}, imem_addr, tgt + 32'd4);
    advance();
    idle(1);
    apply(1'b0, 1'b0, 1'b0, 32'h0);
    chk({tag, "_pc2"}, if_pc, tgt + 32'd4);
    chk({tag, "_mis2"}, {31'b0, if_misalign}, 32'h0);
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_pc;
    logic        exp_mis;
    int          consumed, quiet;
    bit          st, rv;
    logic [31:0] rpc;

    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    @(negedge clk);

    // ---- cycle table: sequential fetch, then a 5-cycle stall into HOLD ----
    tbl[0]  = mk(0, 1, 32'h00, 0, 32'h0, NOP, ST_FETCH);
    tbl[1]  = mk(0, 0, 32'h00, 0, 32'h0, NOP, ST_WAIT);
    tbl[2]  = mk(0, 1, 32'h04, 1, 32'h0, 32'h0050_0093, ST_FETCH);
    tbl[3]  = mk(0, 0, 32'h00, 0, 32'h0, NOP, ST_WAIT);
    tbl[4]  = mk(0, 1, 32'h08, 1, 32'h4, 32'h00a0_0113, ST_FETCH);
    tbl[5]  = mk(0, 0, 32'h00, 0, 32'h0, NOP, ST_WAIT);
    tbl[6]  = mk(1, 1, 32'h0C, 1, 32'h8, mem_word(32'h8), ST_FETCH);
    tbl[7]  = mk(1, 0, 32'h00, 1, 32'h8, mem_word(32'h8), ST_WAIT);
    tbl[8]  = mk(1, 0, 32'h00, 1, 32'h8, mem_word(32'h8), ST_HOLD);
    tbl[9]  = mk(1, 0, 32'h00, 1, 32'h8, mem_word(32'h8), ST_HOLD);
    tbl[10] = mk(1, 0, 32'h00, 1, 32'h8, mem_word(32'h8), ST_HOLD);
    tbl[11] = mk(0, 0, 32'h00, 1, 32'h8, mem_word(32'h8), ST_HOLD);
    tbl[12] = mk(0, 1, 32'h10, 1, 32'hC, mem_word(32'hC), ST_FETCH);
    tbl[13] = mk(0, 0, 32'h00, 0, 32'h0, NOP, ST_WAIT);

    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].st, 1'b0, 1'b0, 32'h0);
      chk($sformatf("tbl%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].exp_req});
      if (tbl[i].exp_req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_valid", i), {31'b0, if_valid}, {31'b0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) chk($sformatf("tbl%0d_pc", i), if_pc, tbl[i].exp_pc);
      chk($sformatf("tbl%0d_instr", i), if_instr, tbl[i].exp_instr);
      chk($sformatf("tbl%0d_state", i), 32'(dbg_state), 32'(tbl[i].exp_state));
      advance();
    end

    // ---- redirect while waiting; stale 0xDEADBEEF must never appear ----
    do_reset();
    lat_min = 2; lat_max = 2;
    idle(1);
    poison = 1'b1;
    apply(1'b0, 1'b0, 1'b1, 32'h100);
    chk("redir_wait_state", 32'(dbg_state), 32'(ST_WAIT));
    advance();
    for (int k = 2; k <= 5; k++) begin
      apply(1'b0, 1'b0, 1'b0, 32'h0);
      chk($sformatf("redir_quiet%0d", k), {31'b0, if_valid}, 32'h0);
      if (k == 3) begin
        chk("redir_req", {31'b0, imem_req}, 32'h1);
        chk("redir_addr", imem_addr, 32'h100);
      end
      advance();
    end
    apply(1'b0, 1'b0, 1'b0, 32'h0);
    chk("redir_valid", {31'b0, if_valid}, 32'h1);
    chk("redir_pc", if_pc, 32'h100);
    chk("redir_instr", if_instr, mem_word(32'h100));
    advance();

    redirect_from_fetch("misalign", 32'h102);
    redirect_from_fetch("wrap", 32'hFFFF_FFFC);

    // ---- flush together with stall: flush wins, in-flight fetch still lands ----
    do_reset();
    lat_min = 1; lat_max = 1;
    idle(2);
    apply(1'b1, 1'b1, 1'b0, 32'h0);
    chk("flush_pre_valid", {31'b0, if_valid}, 32'h1);
    advance();
    apply(1'b0, 1'b0, 1'b0, 32'h0);
    chk("flush_valid", {31'b0, if_valid}, 32'h0);
    chk("flush_instr", if_instr, NOP);
    advance();
    apply(1'b0, 1'b0, 1'b0, 32'h0);
    chk("flush_next_valid", {31'b0, if_valid}, 32'h1);
    chk("flush_next_pc", if_pc, 32'h4);
    advance();

    // ---- reset mid-WAIT, stale response one cycle after reset ----
    do_reset();
    lat_min = 2; lat_max = 2;
    idle(1);
    rst = 1'b1;
    poison = 1'b1;
    apply(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rstw_req", {31'b0, imem_req}, 32'h0);
    advance();
    rst = 1'b0;
    apply(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rstw_stale_rvalid", {31'b0, imem_rvalid}, 32'h1);
    chk("rstw_req_after", {31'b0, imem_req}, 32'h1);
    chk("rstw_addr", imem_addr, 32'h0);
    chk("rstw_valid", {31'b0, if_valid}, 32'h0);
    chk("rstw_pc", if_pc, 32'h0);
    chk("rstw_instr", if_instr, NOP);
    chk("rstw_mis", {31'b0, if_misalign}, 32'h0);
    advance();
    for (int k = 0; k < 2; k++) begin
      apply(1'b0, 1'b0, 1'b0, 32'h0);
      chk($sformatf("rstw_quiet%0d", k), {31'b0, if_valid}, 32'h0);
      advance();
    end
    apply(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rstw_first_valid", {31'b0, if_valid}, 32'h1);
    chk("rstw_first_pc", if_pc, 32'h0);
    chk("rstw_first_instr", if_instr, mem_word(32'h0));
    advance();

    // ---- random stalls/redirects against an instruction-stream model ----
    do_reset();
    lat_min = 1; lat_max = 3;
    exp_pc = 32'h0; exp_mis = 1'b0; consumed = 0; quiet = 0;
    for (int c = 0; c < 800; c++) begin
      st = ($urandom_range(99, 0) < 30);
      rv = ($urandom_range(99, 0) < 4);
      if ($urandom_range(1, 0) == 0) rpc = $urandom_range(32'h3FF, 0);
      else rpc = 32'hFFFF_FFF0 + $urandom_range(15, 0);
      apply(st, 1'b0, rv, rpc);
      if (if_valid && !st && !rv) begin
        chk("rand_pc", if_pc, exp_pc);
        chk("rand_instr", if_instr, mem_word(exp_pc));
        chk("rand_mis", {31'b0, if_misalign}, {31'b0, exp_mis});
        exp_pc  = exp_pc + 32'd4;
        exp_mis = 1'b0;
        consumed++;
        quiet = 0;
      end else begin
        quiet++;
      end
      if (rv) begin
        exp_pc  = rpc & ~32'h3;
        exp_mis = |rpc[1:0];
      end
      advance();
      if (quiet > 60) begin
        n_checks++;
        n_fail++;
        $display("FAIL rand_watchdog: no instruction delivered for %0d cycles", quiet);
        break;
      end
    end
    chk("rand_progress", {31'b0, consumed >= 40}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
